// File: rtl/cache_port_arbiter_pkg.sv
// Shared widths and the request record exchanged between the port arbiter and the cache core.
package cache_port_arbiter_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 512;
  localparam int MASK_W = 64;
  localparam int PORT_W = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
    logic              lock;
    logic [PORT_W-1:0] port;
  } cache_req_t;

  // Index width that stays legal for a single-entry range.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Upstream request/response ports and the cache-core request/response channel.
// master: the arbiter; slave: requesters plus cache core.
interface cache_port_arbiter_if #(parameter int NUM_PORTS = 4);
  import cache_port_arbiter_pkg::*;

  logic [NUM_PORTS-1:0]             up_req_valid;
  logic [NUM_PORTS-1:0]             up_req_ready;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] up_req_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] up_req_data;
  logic [NUM_PORTS-1:0][MASK_W-1:0] up_req_mask;
  logic [NUM_PORTS-1:0]             up_req_lock;

  logic [NUM_PORTS-1:0]             up_resp_valid;
  logic [NUM_PORTS-1:0]             up_resp_ready;
  logic [DATA_W-1:0]                up_resp_data;
  logic                             up_resp_success;

  logic                             io_request_valid;
  logic                             io_request_ready;
  logic [ADDR_W-1:0]                io_request_bits_addr;
  logic [DATA_W-1:0]                io_request_bits_data;
  logic [MASK_W-1:0]                io_request_bits_mask;
  logic                             io_request_bits_lock;
  logic [PORT_W-1:0]                io_request_bits_port;

  logic                             io_response_valid;
  logic                             io_response_ready;
  logic [DATA_W-1:0]                io_response_bits_data;
  logic                             io_response_bits_success;

  modport master (
    input  up_req_valid, up_req_addr, up_req_data, up_req_mask, up_req_lock, up_resp_ready,
           io_request_ready, io_response_valid, io_response_bits_data, io_response_bits_success,
    output up_req_ready, up_resp_valid, up_resp_data, up_resp_success,
           io_request_valid, io_request_bits_addr, io_request_bits_data, io_request_bits_mask,
           io_request_bits_lock, io_request_bits_port, io_response_ready
  );

  modport slave (
    output up_req_valid, up_req_addr, up_req_data, up_req_mask, up_req_lock, up_resp_ready,
           io_request_ready, io_response_valid, io_response_bits_data, io_response_bits_success,
    input  up_req_ready, up_resp_valid, up_resp_data, up_resp_success,
           io_request_valid, io_request_bits_addr, io_request_bits_data, io_request_bits_mask,
           io_request_bits_lock, io_request_bits_port, io_response_ready
  );

endinterface

// File: rtl/cache_tag_fifo.sv
// In-order tag FIFO remembering which upstream port owns each in-flight cache request.
module cache_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             data_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: non-blocking (<=) for every register so all flops sample pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter of NUM_PORTS requesters onto one cache port with in-order response routing.
// Optional grant holding for locked sequences: define CACHE_ARB_LOCK_EN.
module cache_port_arbiter
  import cache_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int OUTST_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cache_port_arbiter_if.master  arb_if
);

  localparam int IDX_W = idx_width(NUM_PORTS);
  localparam int CNT_W = $clog2(OUTST_DEPTH + 1);

  logic             armed_q;
  logic             out_valid_q;
  cache_req_t       out_req_q, out_req_d;
  logic [IDX_W-1:0] last_grant_q, gnt_idx, head_idx, hold_port;
  logic             gnt_valid, can_accept, accept, resp_fire, hold_active;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

`ifdef CACHE_ARB_LOCK_EN
  logic             lock_hold_q;
  logic [IDX_W-1:0] lock_port_q;

  // The hold follows the lock bit of each accepted request from the held port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_hold_q <= 1'b0;
      lock_port_q <= '0;
    end else if (accept) begin
      lock_hold_q <= arb_if.up_req_lock[gnt_idx];
      lock_port_q <= gnt_idx;
    end
  end

  assign hold_active = lock_hold_q;
  assign hold_port   = lock_port_q;
`else
  assign hold_active = 1'b0;
  assign hold_port   = '0;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = last_grant_q;
    if (hold_active) begin
      gnt_valid = arb_if.up_req_valid[hold_port];
      gnt_idx   = hold_port;
    end else begin
      for (int i = 1; i <= NUM_PORTS; i++) begin
        if (!gnt_valid && arb_if.up_req_valid[IDX_W'((int'(last_grant_q) + i) % NUM_PORTS)]) begin
          gnt_valid = 1'b1;
          gnt_idx   = IDX_W'((int'(last_grant_q) + i) % NUM_PORTS);
        end
      end
    end
  end

  // armed_q keeps every ready low during reset and the first cycle after release.
  assign can_accept = armed_q && (!out_valid_q || arb_if.io_request_ready) && !fifo_full;
  assign accept     = can_accept && gnt_valid;

  always_comb begin
    arb_if.up_req_ready = '0;
    if (accept) arb_if.up_req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    out_req_d.addr = arb_if.up_req_addr[gnt_idx];
    out_req_d.data = arb_if.up_req_data[gnt_idx];
    out_req_d.mask = arb_if.up_req_mask[gnt_idx];
    out_req_d.lock = arb_if.up_req_lock[gnt_idx];
    out_req_d.port = PORT_W'(gnt_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
    end else begin
      armed_q <= 1'b1;
      if (accept) begin
        out_valid_q  <= 1'b1;
        last_grant_q <= gnt_idx;
      end else if (arb_if.io_request_ready) begin
        out_valid_q  <= 1'b0;
      end
    end
  end

  // Payload only loads on acceptance, so it stays frozen while the cache stalls.
  always_ff @(posedge clk) begin
    if (accept) out_req_q <= out_req_d;
  end

  assign arb_if.io_request_valid     = out_valid_q;
  assign arb_if.io_request_bits_addr = out_req_q.addr;
  assign arb_if.io_request_bits_data = out_req_q.data;
  assign arb_if.io_request_bits_mask = out_req_q.mask;
  assign arb_if.io_request_bits_lock = out_req_q.lock;
  assign arb_if.io_request_bits_port = out_req_q.port;

  cache_tag_fifo #(
    .DEPTH (OUTST_DEPTH),
    .WIDTH (IDX_W)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .pop_i   (resp_fire),
    .data_i  (gnt_idx),
    .data_o  (head_idx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Responses with no tag outstanding stall at the cache rather than being dropped.
  always_comb begin
    arb_if.up_resp_valid = '0;
    if (arb_if.io_response_valid && !fifo_empty) arb_if.up_resp_valid[head_idx] = 1'b1;
  end

  assign arb_if.io_response_ready = !fifo_empty && arb_if.up_resp_ready[head_idx];
  assign arb_if.up_resp_data      = arb_if.io_response_bits_data;
  assign arb_if.up_resp_success   = arb_if.io_response_bits_success;
  assign resp_fire                = arb_if.io_response_valid && arb_if.io_response_ready;

  count_bound_a : assert property (@(posedge clk) disable iff (!rst_n)
    fifo_count <= CNT_W'(OUTST_DEPTH));

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: reset, single request, fairness, backpressure,
// outstanding limit, response ordering, mid-burst reset and lock holding.
module tb_cache_port_arbiter;
  import cache_port_arbiter_pkg::*;

  localparam int NP = 4;

`ifdef CACHE_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  cache_port_arbiter_if #(.NUM_PORTS(NP)) bus ();

  cache_port_arbiter #(.NUM_PORTS(NP), .OUTST_DEPTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_if (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.up_req_valid             = '0;
    bus.up_req_addr              = '0;
    bus.up_req_data              = '0;
    bus.up_req_mask              = '0;
    bus.up_req_lock              = '0;
    bus.up_resp_ready            = '0;
    bus.io_request_ready         = 1'b0;
    bus.io_response_valid        = 1'b0;
    bus.io_response_bits_data    = '0;
    bus.io_response_bits_success = 1'b0;

    // Reset: everything low even with valids and readies pushed high.
    bus.up_req_valid      = '1;
    bus.io_response_valid = 1'b1;
    bus.up_resp_ready     = '1;
    step();
    step();
    check("rst_up_req_ready",  64'(bus.up_req_ready),      64'h0);
    check("rst_io_req_valid",  64'(bus.io_request_valid),  64'h0);
    check("rst_up_resp_valid", 64'(bus.up_resp_valid),     64'h0);
    check("rst_io_resp_ready", 64'(bus.io_response_ready), 64'h0);
    bus.io_response_valid = 1'b0;
    bus.up_resp_ready     = '0;
    rst_n = 1'b1;
    #1;
    check("rel_up_req_ready", 64'(bus.up_req_ready), 64'h0);
    bus.up_req_valid = '0;
    step();

    // Single request from port 2.
    bus.up_req_valid   = 4'b0100;
    bus.up_req_addr[2] = 24'h40;
    bus.up_req_data[2] = 512'h2;
    bus.up_req_mask[2] = '1;
    #1;
    check("t1_ready", 64'(bus.up_req_ready), 64'h4);
    step();
    bus.up_req_valid = '0;
    #1;
    check("t1_valid", 64'(bus.io_request_valid),     64'h1);
    check("t1_port",  64'(bus.io_request_bits_port), 64'h2);
    check("t1_addr",  64'(bus.io_request_bits_addr), 64'h40);
    check("t1_data",  64'(bus.io_request_bits_data), 64'h2);
    check("t1_mask",  64'(bus.io_request_bits_mask), 64'hFFFF_FFFF_FFFF_FFFF);
    check("t1_lock",  64'(bus.io_request_bits_lock), 64'h0);
    bus.io_request_ready = 1'b1;
    step();
    check("t1_drain", 64'(bus.io_request_valid), 64'h0);
    bus.io_response_valid        = 1'b1;
    bus.io_response_bits_data    = 512'h3;
    bus.io_response_bits_success = 1'b1;
    #1;
    check("t1_resp_valid",   64'(bus.up_resp_valid),     64'h4);
    check("t1_resp_stall",   64'(bus.io_response_ready), 64'h0);
    check("t1_resp_data",    64'(bus.up_resp_data),      64'h3);
    check("t1_resp_success", 64'(bus.up_resp_success),   64'h1);
    bus.up_resp_ready = 4'b0100;
    #1;
    check("t1_resp_ready", 64'(bus.io_response_ready), 64'h1);
    step();
    check("t1_stray_valid", 64'(bus.up_resp_valid),     64'h0);
    check("t1_stray_ready", 64'(bus.io_response_ready), 64'h0);
    bus.io_response_valid = 1'b0;
    bus.up_resp_ready     = '0;

    // Fairness from a fresh reset: all ports valid, cache always ready.
    do_reset();
    for (int p = 0; p < NP; p++) bus.up_req_addr[p] = 24'(24'h000A00 + p);
    bus.up_req_valid      = '1;
    bus.io_request_ready  = 1'b1;
    bus.io_response_valid = 1'b1;
    bus.up_resp_ready     = '1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("fair_grant", 64'(bus.up_req_ready), 64'(1) << (i % 4));
      if (i > 0) check("fair_port", 64'(bus.io_request_bits_port), 64'((i - 1) % 4));
      step();
    end
    bus.up_req_valid = '0;
    #1;
    check("fair_last_port", 64'(bus.io_request_bits_port), 64'h3);
    step();
    check("fair_empty", 64'(bus.up_resp_valid), 64'h0);
    bus.io_response_valid = 1'b0;

    // Backpressure: one acceptance, then nothing for 10 stalled cycles.
    bus.io_request_ready = 1'b0;
    bus.up_req_valid     = '1;
    #1;
    check("bp_first_grant", 64'(bus.up_req_ready), 64'h1);
    step();
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_no_ready", 64'(bus.up_req_ready), 64'h0);
      check("bp_stable", {30'h0, bus.io_request_valid, bus.io_request_bits_port, bus.io_request_bits_addr, 5'h0},
            {30'h0, 1'b1, 4'h0, 24'h000A00, 5'h0});
      step();
    end
    bus.io_request_ready = 1'b1;
    #1;
    check("bp_release_grant", 64'(bus.up_req_ready), 64'h2);
    step();
    bus.up_req_valid = '0;
    #1;
    check("bp_release_port", 64'(bus.io_request_bits_port), 64'h1);
    step();

    // Outstanding limit: four accepted, fifth refused until a response pops.
    do_reset();
    bus.up_req_valid = '1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("lim_grant", 64'(bus.up_req_ready), 64'(1) << i);
      step();
    end
    check("lim_fifth_a", 64'(bus.up_req_ready), 64'h0);
    step();
    check("lim_fifth_b", 64'(bus.up_req_ready), 64'h0);
    bus.io_response_valid     = 1'b1;
    bus.io_response_bits_data = 512'h55;
    bus.up_resp_ready         = '1;
    #1;
    check("lim_resp_head", 64'(bus.up_resp_valid), 64'h1);
    check("lim_pop_full",  64'(bus.up_req_ready),  64'h0);
    check("lim_resp_data", 64'(bus.up_resp_data),  64'h55);
    step();
    bus.io_response_valid = 1'b0;
    #1;
    check("lim_after_pop", 64'(bus.up_req_ready), 64'h1);
    step();
    bus.up_req_valid = '0;

    // Ordering: tags now 1,2,3,0; port 3 stalls and port 0 must wait behind it.
    bus.io_response_valid = 1'b1;
    #1;
    check("ord_head1", 64'(bus.up_resp_valid), 64'h2);
    step();
    check("ord_head2", 64'(bus.up_resp_valid), 64'h4);
    step();
    bus.up_resp_ready = 4'b0001;
    #1;
    check("ord_head3",     64'(bus.up_resp_valid),     64'h8);
    check("ord_stall",     64'(bus.io_response_ready), 64'h0);
    step();
    check("ord_held",      64'(bus.up_resp_valid),     64'h8);
    bus.up_resp_ready = 4'b1001;
    #1;
    check("ord_go",        64'(bus.io_response_ready), 64'h1);
    step();
    check("ord_head0",     64'(bus.up_resp_valid),     64'h1);

    // Reset mid-burst with a tag still outstanding.
    bus.up_req_valid = '1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_resp_valid", 64'(bus.up_resp_valid),     64'h0);
    check("mid_rst_resp_ready", 64'(bus.io_response_ready), 64'h0);
    check("mid_rst_req_ready",  64'(bus.up_req_ready),      64'h0);
    check("mid_rst_io_valid",   64'(bus.io_request_valid),  64'h0);
    step();
    rst_n = 1'b1;
    #1;
    check("mid_rel_resp_valid", 64'(bus.up_resp_valid), 64'h0);
    check("mid_rel_req_ready",  64'(bus.up_req_ready),  64'h0);
    bus.up_req_valid = '0;
    step();

    // Lock: port 1 opens a locked sequence while ports 0 and 3 compete.
    bus.up_resp_ready  = '1;
    bus.up_req_valid   = 4'b0010;
    bus.up_req_lock[1] = 1'b1;
    bus.up_req_addr[1] = 24'h010040;
    #1;
    check("lock_first", 64'(bus.up_req_ready), 64'h2);
    step();
    bus.up_req_valid = 4'b1011;
    #1;
    check("lock_hold",      64'(bus.up_req_ready), LOCK_EN ? 64'h2 : 64'h8);
    check("lock_fwd_bit",   64'(bus.io_request_bits_lock), 64'h1);
    check("lock_fwd_addr",  64'(bus.io_request_bits_addr), 64'h010040);
    step();
    bus.up_req_lock[1] = 1'b0;
    bus.up_req_addr[1] = 24'h020040;
    #1;
    check("lock_unlock_req", 64'(bus.up_req_ready), LOCK_EN ? 64'h2 : 64'h1);
    step();
    check("lock_resume", 64'(bus.up_req_ready), LOCK_EN ? 64'h8 : 64'h2);
    check("lock_clear_bit", 64'(bus.io_request_bits_lock), 64'h0);
    step();
    bus.up_req_valid      = '0;
    bus.io_response_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
